// File: rtl/id_ex_pipe.sv
//------------------------------------------------------------------------------
// id_ex_pipe
//
// Pipeline stage between decode (id) and execute (ex) of the MIPS32 core.
// It uses a valid/ready handshake on both sides and has two storage slots:
// the output register (OUT) and one skid register (SK). Because of the skid
// slot, id_ready can come straight from a flop. A stall on the execute side
// therefore never makes a combinational path back into decode.
//
// A synchronous flush empties both slots. A saturating counter, bubble_cnt,
// records how many cycles the output held no valid instruction.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   flush               drop everything held and anything arriving this cycle
//   id_valid/id_ready   upstream handshake (id_ready is registered)
//   id_*                incoming payload (don't-care while id_valid=0)
//   ex_valid/ex_ready   downstream handshake (ex_valid is registered)
//   ex_*                registered payload; NOP/zero while ex_valid=0
//   bubble_cnt          saturating count of cycles with ex_valid=0
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module id_ex_pipe #(
   parameter int                  DATA_W   = 32,
   parameter int                  ADDR_W   = 5,
   parameter int                  ALUOP_W  = 8,
   parameter int                  ALUSEL_W = 3,
   parameter int                  CNT_W    = 16,
   parameter logic [ALUOP_W-1:0]  NOP_OP   = 8'h00,
   parameter logic [ALUSEL_W-1:0] NOP_SEL  = 3'b000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,

   input  logic                id_valid,
   output logic                id_ready,
   input  logic [ALUOP_W-1:0]  id_aluop,
   input  logic [ALUSEL_W-1:0] id_alusel,
   input  logic [DATA_W-1:0]   id_reg1,
   input  logic [DATA_W-1:0]   id_reg2,
   input  logic [ADDR_W-1:0]   id_wd,
   input  logic                id_wreg,
   input  logic                id_in_delayslot,
   input  logic [DATA_W-1:0]   id_link_addr,
   input  logic [DATA_W-1:0]   id_inst,

   output logic                ex_valid,
   input  logic                ex_ready,
   output logic [ALUOP_W-1:0]  ex_aluop,
   output logic [ALUSEL_W-1:0] ex_alusel,
   output logic [DATA_W-1:0]   ex_reg1,
   output logic [DATA_W-1:0]   ex_reg2,
   output logic [ADDR_W-1:0]   ex_wd,
   output logic                ex_wreg,
   output logic                ex_in_delayslot,
   output logic [DATA_W-1:0]   ex_link_addr,
   output logic [DATA_W-1:0]   ex_inst,

   output logic [CNT_W-1:0]    bubble_cnt
);

   typedef struct packed {
      logic [ALUOP_W-1:0]  aluop;
      logic [ALUSEL_W-1:0] alusel;
      logic [DATA_W-1:0]   reg1;
      logic [DATA_W-1:0]   reg2;
      logic [ADDR_W-1:0]   wd;
      logic                wreg;
      logic                in_delayslot;
      logic [DATA_W-1:0]   link_addr;
      logic [DATA_W-1:0]   inst;
   } payload_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   payload_t nop_pl;
   payload_t in_pl;
   payload_t out_q, out_d;
   payload_t sk_q, sk_d;

   logic             ex_valid_q, ex_valid_d;
   logic             sk_valid_q, sk_valid_d;
   logic             id_ready_q;
   logic [CNT_W-1:0] bubble_q, bubble_d;

   logic             accept;
   logic             drain;

   // An empty output shows this NOP encoding. Downstream logic can then
   // ignore ex_valid for write-back, because ex_wreg is always 0 here.
   always_comb begin
      nop_pl        = '0;
      nop_pl.aluop  = NOP_OP;
      nop_pl.alusel = NOP_SEL;
   end

   always_comb begin
      in_pl              = '0;
      in_pl.aluop        = id_aluop;
      in_pl.alusel       = id_alusel;
      in_pl.reg1         = id_reg1;
      in_pl.reg2         = id_reg2;
      in_pl.wd           = id_wd;
      in_pl.wreg         = id_wreg;
      in_pl.in_delayslot = id_in_delayslot;
      in_pl.link_addr    = id_link_addr;
      in_pl.inst         = id_inst;
   end

   assign accept = id_valid & id_ready_q;
   // OUT may be overwritten this cycle: it is empty or being consumed.
   assign drain  = ~ex_valid_q | ex_ready;

   always_comb begin
      out_d      = out_q;
      sk_d       = sk_q;
      ex_valid_d = ex_valid_q;
      sk_valid_d = sk_valid_q;
      bubble_d   = bubble_q;

      if (flush) begin
         // A flush also squashes an accept in the same cycle. The bubble
         // count is deliberately left alone on the flush edge itself.
         out_d      = nop_pl;
         ex_valid_d = 1'b0;
         sk_valid_d = 1'b0;
      end else begin
         if (drain) begin
            if (sk_valid_q) begin
               // id_ready is low while SK is full, so accept is normally 0
               // here. The branch still keeps ordering if it is not.
               out_d      = sk_q;
               ex_valid_d = 1'b1;
               if (accept) begin
                  sk_d = in_pl;
               end
               sk_valid_d = accept;
            end else if (accept) begin
               out_d      = in_pl;
               ex_valid_d = 1'b1;
            end else begin
               out_d      = nop_pl;
               ex_valid_d = 1'b0;
            end
         end else if (accept) begin
            sk_d       = in_pl;
            sk_valid_d = 1'b1;
         end

         if (!ex_valid_d && (bubble_q != CNT_MAX)) begin
            bubble_d = bubble_q + CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q      <= nop_pl;
         sk_q       <= '0;
         ex_valid_q <= 1'b0;
         sk_valid_q <= 1'b0;
         id_ready_q <= 1'b1;
         bubble_q   <= '0;
      end else begin
         out_q      <= out_d;
         sk_q       <= sk_d;
         ex_valid_q <= ex_valid_d;
         sk_valid_q <= sk_valid_d;
         // This flop copies ~sk_valid. It is kept separate so that id_ready
         // comes directly from a flop.
         id_ready_q <= ~sk_valid_d;
         bubble_q   <= bubble_d;
      end
   end

   assign id_ready        = id_ready_q;
   assign ex_valid        = ex_valid_q;
   assign ex_aluop        = out_q.aluop;
   assign ex_alusel       = out_q.alusel;
   assign ex_reg1         = out_q.reg1;
   assign ex_reg2         = out_q.reg2;
   assign ex_wd           = out_q.wd;
   assign ex_wreg         = out_q.wreg;
   assign ex_in_delayslot = out_q.in_delayslot;
   assign ex_link_addr    = out_q.link_addr;
   assign ex_inst         = out_q.inst;
   assign bubble_cnt      = bubble_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
`timescale 1ns/1ps

module tb_id_ex_pipe;

   typedef struct packed {
      logic [7:0]  aluop;
      logic [2:0]  alusel;
      logic [31:0] reg1;
      logic [31:0] reg2;
      logic [4:0]  wd;
      logic        wreg;
      logic        ds;
      logic [31:0] link;
      logic [31:0] inst;
   } pl_t;

   logic        clk = 1'b0;
   logic        rst, flush, id_valid, ex_ready;
   logic        id_ready, ex_valid;
   pl_t         in_p;
   logic [7:0]  ex_aluop;
   logic [2:0]  ex_alusel;
   logic [31:0] ex_reg1, ex_reg2, ex_link_addr, ex_inst;
   logic [4:0]  ex_wd;
   logic        ex_wreg, ex_in_delayslot;
   logic [15:0] bubble_cnt;

   // Small-counter instance, held idle, for the saturation check.
   logic        s_id_ready, s_ex_valid, s_ex_wreg, s_ex_ds;
   logic [7:0]  s_aluop;
   logic [2:0]  s_alusel;
   logic [31:0] s_reg1, s_reg2, s_link, s_inst;
   logic [4:0]  s_wd;
   logic [1:0]  s_bubble;
   logic        s_id_valid = 1'b0;
   logic        s_ex_ready = 1'b1;

   int n_pass = 0;
   int n_total = 0;
   pl_t exp_q[$];

   always #5 clk = ~clk;

   id_ex_pipe dut (
      .clk(clk), .rst(rst), .flush(flush),
      .id_valid(id_valid), .id_ready(id_ready),
      .id_aluop(in_p.aluop), .id_alusel(in_p.alusel),
      .id_reg1(in_p.reg1), .id_reg2(in_p.reg2),
      .id_wd(in_p.wd), .id_wreg(in_p.wreg),
      .id_in_delayslot(in_p.ds), .id_link_addr(in_p.link), .id_inst(in_p.inst),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_aluop(ex_aluop), .ex_alusel(ex_alusel),
      .ex_reg1(ex_reg1), .ex_reg2(ex_reg2),
      .ex_wd(ex_wd), .ex_wreg(ex_wreg),
      .ex_in_delayslot(ex_in_delayslot), .ex_link_addr(ex_link_addr), .ex_inst(ex_inst),
      .bubble_cnt(bubble_cnt)
   );

   id_ex_pipe #(.CNT_W(2)) dut_small (
      .clk(clk), .rst(rst), .flush(1'b0),
      .id_valid(s_id_valid), .id_ready(s_id_ready),
      .id_aluop(in_p.aluop), .id_alusel(in_p.alusel),
      .id_reg1(in_p.reg1), .id_reg2(in_p.reg2),
      .id_wd(in_p.wd), .id_wreg(in_p.wreg),
      .id_in_delayslot(in_p.ds), .id_link_addr(in_p.link), .id_inst(in_p.inst),
      .ex_valid(s_ex_valid), .ex_ready(s_ex_ready),
      .ex_aluop(s_aluop), .ex_alusel(s_alusel),
      .ex_reg1(s_reg1), .ex_reg2(s_reg2),
      .ex_wd(s_wd), .ex_wreg(s_ex_wreg),
      .ex_in_delayslot(s_ex_ds), .ex_link_addr(s_link), .ex_inst(s_inst),
      .bubble_cnt(s_bubble)
   );

   task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic pl_t mk(input logic [31:0] r1, input logic ds, input logic [31:0] la);
      pl_t p;
      p.aluop  = 8'h20 | r1[7:0];
      p.alusel = 3'b001;
      p.reg1   = r1;
      p.reg2   = ~r1;
      p.wd     = r1[4:0] | 5'd1;
      p.wreg   = 1'b1;
      p.ds     = ds;
      p.link   = la;
      p.inst   = 32'h0C00_0000 | r1;
      return p;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input pl_t p, input bit expect_accept);
      id_valid = 1'b1;
      in_p     = p;
      if (expect_accept) exp_q.push_back(p);
   endtask

   task automatic idle();
      id_valid = 1'b0;
      in_p     = pl_t'({5{$urandom()}});
   endtask

   // Monitor: every transfer on the execute side pops the next expected payload.
   always @(negedge clk) begin
      if (!rst && !flush && ex_valid && ex_ready) begin
         if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_out: got reg1=%0h expected no transfer", ex_reg1);
         end else begin
            pl_t e;
            pl_t a;
            e = exp_q.pop_front();
            a = '{ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg,
                  ex_in_delayslot, ex_link_addr, ex_inst};
            chk("payload", 160'(a), 160'(e));
         end
      end
   end

   initial begin
      // Reset with a valid instruction presented: it must be dropped.
      rst = 1'b1; flush = 1'b0; ex_ready = 1'b0;
      id_valid = 1'b1; in_p = pl_t'({5{$urandom()}});
      in_p.wreg = 1'b1;
      tick(); tick();
      chk("rst_ex_valid", 160'(ex_valid), 160'(0));
      chk("rst_ex_wreg",  160'(ex_wreg),  160'(0));
      chk("rst_ex_aluop", 160'(ex_aluop), 160'(8'h00));
      chk("rst_id_ready", 160'(id_ready), 160'(1));
      chk("rst_bubble",   160'(bubble_cnt), 160'(0));
      rst = 1'b0; ex_ready = 1'b1; idle();

      // Streaming: A, B, C on consecutive cycles.
      drive(mk(32'd1, 1'b0, 32'h0), 1); tick();               // e3
      chk("str_reg1_a", 160'(ex_reg1), 160'(1));
      chk("str_rdy_a",  160'(id_ready), 160'(1));
      drive(mk(32'd2, 1'b0, 32'h0), 1); tick();               // e4
      chk("str_reg1_b", 160'(ex_reg1), 160'(2));
      chk("small_bub2", 160'(s_bubble), 160'(2));
      drive(mk(32'd3, 1'b0, 32'h0), 1); tick();               // e5
      chk("str_reg1_c", 160'(ex_reg1), 160'(3));
      chk("str_rdy_c",  160'(id_ready), 160'(1));
      idle(); tick();                                         // e6
      chk("str_empty",  160'(ex_valid), 160'(0));
      chk("bubble_1",   160'(bubble_cnt), 160'(1));
      chk("small_sat",  160'(s_bubble), 160'(3));

      // Skid: A2 then B2 (delay slot, link address) while execute stalls.
      ex_ready = 1'b0;
      drive(mk(32'h11, 1'b0, 32'h0), 1); tick();              // e7
      chk("sk_valid_a", 160'(ex_valid), 160'(1));
      chk("sk_rdy_a",   160'(id_ready), 160'(1));
      drive(mk(32'h22, 1'b1, 32'h0040_0008), 1); tick();      // e8
      chk("sk_rdy_full", 160'(id_ready), 160'(0));
      chk("sk_out_a",    160'(ex_reg1), 160'(32'h11));
      idle(); tick();                                         // e9
      chk("sk_hold_rdy", 160'(id_ready), 160'(0));
      chk("sk_hold_a",   160'(ex_reg1), 160'(32'h11));
      ex_ready = 1'b1; tick();                                // e10
      chk("sk_rdy_back", 160'(id_ready), 160'(1));
      chk("sk_out_b",    160'(ex_reg1), 160'(32'h22));
      chk("ds_bit",      160'(ex_in_delayslot), 160'(1));
      chk("link_addr",   160'(ex_link_addr), 160'(32'h0040_0008));
      tick();                                                 // e11
      chk("sk_empty",    160'(ex_valid), 160'(0));
      chk("bubble_2",    160'(bubble_cnt), 160'(2));

      // Flush with a full skid and a new instruction presented.
      ex_ready = 1'b0;
      drive(mk(32'h33, 1'b0, 32'h0), 1); tick();              // e12
      drive(mk(32'h44, 1'b0, 32'h0), 1); tick();              // e13
      chk("fl_full_rdy", 160'(id_ready), 160'(0));
      drive(mk(32'h55, 1'b0, 32'h0), 0);
      flush = 1'b1;
      exp_q.delete();
      tick();                                                 // e14
      flush = 1'b0; idle();
      chk("fl_valid",   160'(ex_valid), 160'(0));
      chk("fl_rdy",     160'(id_ready), 160'(1));
      chk("fl_wreg",    160'(ex_wreg), 160'(0));
      chk("fl_aluop",   160'(ex_aluop), 160'(8'h00));
      chk("fl_bubble",  160'(bubble_cnt), 160'(2));
      tick();                                                 // e15
      chk("fl_bubble_next", 160'(bubble_cnt), 160'(3));
      chk("fl_no_c",    160'(ex_valid), 160'(0));

      // Empty output for three cycles.
      ex_ready = 1'b1;
      tick(); tick(); tick();                                 // e16..e18
      chk("emp_bubble", 160'(bubble_cnt), 160'(6));
      chk("emp_wreg",   160'(ex_wreg), 160'(0));
      chk("emp_wd",     160'(ex_wd), 160'(0));
      chk("emp_reg1",   160'(ex_reg1), 160'(0));
      chk("emp_inst",   160'(ex_inst), 160'(0));
      chk("emp_alusel", 160'(ex_alusel), 160'(3'b000));

      // Recovery after flush.
      drive(mk(32'h66, 1'b0, 32'h0), 1); tick();              // e19
      chk("rec_valid",  160'(ex_valid), 160'(1));
      idle(); tick();                                         // e20
      tick();
      chk("queue_drained", 160'(exp_q.size()), 160'(0));
      chk("small_nowrap",  160'(s_bubble), 160'(3));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/id_ex_pipe.md
Name: id_ex_pipe

Overview:
- Parametrised ID/EX pipeline stage for the MIPS32 core.
- Replaces a plain capture register with a valid/ready handshake, a 2-entry skid buffer, synchronous flush, and a saturating bubble counter.
- Sits between decode (id) and execute (ex).
- Gives both sides fully registered handshake outputs, so stalls do not create combinational ready paths through the stage.

Parameters:
- DATA_W, 32, operand width (reg1, reg2, link_addr, inst)
- ADDR_W, 5, destination register address width
- ALUOP_W, 8, ALU opcode width
- ALUSEL_W, 3, ALU result-select width
- CNT_W, 16, bubble counter width
- NOP_OP, 8'h00, aluop value driven when the output is empty
- NOP_SEL, 3'b000, alusel value driven when the output is empty

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- flush  in  1  discard all held and incoming instructions
- id_valid  in  1  decode presents an instruction
- id_ready  out  1  stage can accept; registered
- id_aluop  in  ALUOP_W  ALU opcode
- id_alusel  in  ALUSEL_W  result select
- id_reg1  in  DATA_W  operand 1
- id_reg2  in  DATA_W  operand 2
- id_wd  in  ADDR_W  destination register
- id_wreg  in  1  write-enable
- id_in_delayslot  in  1  instruction is in a branch delay slot
- id_link_addr  in  DATA_W  return address for link instructions
- id_inst  in  DATA_W  raw instruction word
- ex_valid  out  1  output holds a valid instruction
- ex_ready  in  1  execute can consume
- ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg, ex_in_delayslot, ex_link_addr, ex_inst  out  matching widths  registered payload
- bubble_cnt  out  CNT_W  saturating count of cycles with ex_valid=0

Behaviour:
- Storage: output register (OUT) plus one skid register (SK) with sk_valid.
- id_ready = ~sk_valid, driven from a flop.
- accept = id_valid & id_ready.
- drain = ~ex_valid | ex_ready, meaning OUT may be overwritten this cycle.
- Priority per cycle: rst > flush > normal.
- rst or flush, effect at the next edge:
  - ex_valid=0 and sk_valid=0, so id_ready=1.
  - ex_aluop=NOP_OP, ex_alusel=NOP_SEL, ex_reg1/reg2/link_addr/inst=0, ex_wd=0, ex_wreg=0, ex_in_delayslot=0.
  - Any accept in the same cycle is dropped.
  - rst additionally clears bubble_cnt to 0; flush does not.
- Normal cycle, by case:
  - drain & sk_valid: OUT<=SK, ex_valid=1. If accept also occurs, the incoming instruction goes into SK and sk_valid stays 1. This case cannot arise, because id_ready=0 whenever sk_valid=1.
  - drain & ~sk_valid & accept: OUT<=incoming, ex_valid=1.
  - drain & ~sk_valid & ~accept: ex_valid<=0 and all OUT payload fields reload their NOP/zero values. ex_wreg=0 is therefore guaranteed whenever ex_valid=0.
  - ~drain & accept: SK<=incoming, sk_valid<=1, so id_ready=0 next cycle.
  - ~drain & ~accept: hold everything.
- Latency: 1 cycle from accept to ex_valid when empty.
- Throughput: 1 instruction/cycle with ex_ready held at 1.
- Ordering is strictly FIFO; no instruction is lost or duplicated.
- Capacity: at most 2 instructions (OUT+SK).
- id_ready falls the cycle after the first stalled accept and rises the cycle after SK drains.
- bubble_cnt increments every cycle in which ex_valid=0 after the edge.
- bubble_cnt saturates at 2^CNT_W-1 and does not wrap.
- Payload inputs are don't-care when id_valid=0.

Test Plan:
- Reset: rst=1 for 2 cycles with id_valid=1 and random payload → ex_valid=0, ex_wreg=0, ex_aluop=NOP_OP, id_ready=1, bubble_cnt=0.
- Streaming: ex_ready=1; ids A,B,C (reg1=1,2,3) on consecutive cycles → ex_reg1 = 1,2,3 on the next three cycles; id_ready stays 1.
- Skid: A then B presented while ex_ready=0 → OUT=A, SK=B, id_ready=0. Raise ex_ready → A, then B, consumed in order; id_ready returns to 1 one cycle after SK empties.
- Flush with full skid: OUT=A, SK=B, flush=1 with id_valid=1 (C) → next cycle ex_valid=0, id_ready=1, C not delivered; bubble_cnt keeps its pre-flush value and increments the following cycle.
- Empty output: no accepts for 3 cycles → ex_wreg=0, ex_wd=0, bubble_cnt +3. With CNT_W=2 and 5 idle cycles after reset → bubble_cnt=3.
- Delay slot: id_in_delayslot=1, id_link_addr=0x00400008 accepted under stall → both appear unchanged with the instruction when it reaches OUT.
